// File: rtl/ram_arbiter_dual.sv
// Two-port arbiter in front of one synchronous RAM (1-cycle read latency), with locked bursts.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise port 1 has fixed priority.
module ram_arbiter_dual #(
    parameter int width     = 16,
    parameter int add_width = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 we0,
    input  logic                 lock0,
    input  logic [add_width-1:0] add0,
    input  logic [width-1:0]     wr0,
    output logic                 gnt0,
    output logic                 vld0,
    output logic [width-1:0]     rd0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic                 lock1,
    input  logic [add_width-1:0] add1,
    input  logic [width-1:0]     wr1,
    output logic                 gnt1,
    output logic                 vld1,
    output logic [width-1:0]     rd1,
    output logic                 mem_we,
    output logic [add_width-1:0] mem_add,
    output logic [width-1:0]     mem_wr,
    input  logic [width-1:0]     mem_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             rd_vld_q, rd_vld_d;
    logic             rd_own_q, rd_own_d;
    logic [width-1:0] rd0_q, rd0_d;
    logic [width-1:0] rd1_q, rd1_d;
    logic             locked;
    logic             pick1;
`ifdef RAM_ARB_RR_EN
    logic             rr_q, rr_d;
`endif

    // Grant selection: a live lock owner wins outright, otherwise the priority rule decides.
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        locked = 1'b0;
        pick1  = 1'b0;
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if ((state_q == OWN0) && req0) begin
            gnt0   = 1'b1;
            locked = 1'b1;
        end else if ((state_q == OWN1) && req1) begin
            gnt1   = 1'b1;
            locked = 1'b1;
        end else if (req0 && req1) begin
`ifdef RAM_ARB_RR_EN
            pick1 = rr_q;
`else
            pick1 = 1'b1;
`endif
            gnt0 = ~pick1;
            gnt1 = pick1;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    // RAM request mux; port 0 fields are forwarded when nobody is granted.
    always_comb begin
        mem_add = add0;
        mem_wr  = wr0;
        mem_we  = 1'b0;
        if (gnt1) begin
            mem_add = add1;
            mem_wr  = wr1;
            mem_we  = we1;
        end else if (gnt0) begin
            mem_we = we0;
        end else begin
            mem_we = 1'b0;
        end
    end

    // Next-state: lock ownership, read-owner tag, read-data hold registers, RR pointer.
    always_comb begin
        state_d  = IDLE;
        rd_vld_d = (gnt0 | gnt1) & ~mem_we;
        rd_own_d = gnt1;
        rd0_d    = rd0_q;
        rd1_d    = rd1_q;
        if (gnt0 && lock0) begin
            state_d = OWN0;
        end else if (gnt1 && lock1) begin
            state_d = OWN1;
        end else begin
            state_d = IDLE;
        end
        if (vld0) begin
            rd0_d = mem_rd;
        end else begin
            rd0_d = rd0_q;
        end
        if (vld1) begin
            rd1_d = mem_rd;
        end else begin
            rd1_d = rd1_q;
        end
`ifdef RAM_ARB_RR_EN
        // The pointer then prefers the port that did not just win.
        if ((gnt0 || gnt1) && !locked) begin
            rr_d = gnt0;
        end else begin
            rr_d = rr_q;
        end
`endif
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_vld_q <= 1'b0;
            rd_own_q <= 1'b0;
            rd0_q    <= {width{1'b0}};
            rd1_q    <= {width{1'b0}};
`ifdef RAM_ARB_RR_EN
            rr_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rd_vld_q <= rd_vld_d;
            rd_own_q <= rd_own_d;
            rd0_q    <= rd0_d;
            rd1_q    <= rd1_d;
`ifdef RAM_ARB_RR_EN
            rr_q     <= rr_d;
`endif
        end
    end

    // RAM data arrives the cycle after the grant, so it is forwarded directly while vld is high.
    assign vld0 = rd_vld_q & ~rd_own_q & ~rst;
    assign vld1 = rd_vld_q & rd_own_q & ~rst;
    assign rd0  = rst ? {width{1'b0}} : (vld0 ? mem_rd : rd0_q);
    assign rd1  = rst ? {width{1'b0}} : (vld1 ? mem_rd : rd1_q);

endmodule

// File: tb/tb_ram_arbiter_dual.sv
// Directed bench for ram_arbiter_dual with a behavioural sync RAM and a read-data scoreboard.
module tb_ram_arbiter_dual;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [12:0] add0, add1;
    logic [15:0] wr0, wr1;
    logic        gnt0, vld0, gnt1, vld1;
    logic [15:0] rd0, rd1;
    logic        mem_we;
    logic [12:0] mem_add;
    logic [15:0] mem_wr;
    logic [15:0] mem_rd;

    int errors = 0;
    int checks = 0;
    int cycn   = 0;

    typedef struct {
        logic        port;
        logic [15:0] data;
        int          due;
    } rd_t;
    rd_t q[$];

    logic [15:0] model_mem [0:8191];
    logic [15:0] exp_rd0, exp_rd1;

    logic [15:0] ram [0:8191];
    logic        written [0:8191];

    ram_arbiter_dual #(.width(16), .add_width(13)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .add0(add0), .wr0(wr0),
        .gnt0(gnt0), .vld0(vld0), .rd0(rd0),
        .req1(req1), .we1(we1), .lock1(lock1), .add1(add1), .wr1(wr1),
        .gnt1(gnt1), .vld1(vld1), .rd1(rd1),
        .mem_we(mem_we), .mem_add(mem_add), .mem_wr(mem_wr), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [12:0] a);
        return {3'b000, a} ^ 16'hA5C3;
    endfunction

    // Behavioural synchronous RAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_add]     <= mem_wr;
            written[mem_add] <= 1'b1;
        end
        mem_rd <= (written[mem_add] === 1'b1) ? ram[mem_add] : init_val(mem_add);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cycn);
        end
    endtask

    task automatic p0(input logic r, input logic w, input logic l, input logic [12:0] a, input logic [15:0] d);
        req0 = r; we0 = w; lock0 = l; add0 = a; wr0 = d;
    endtask

    task automatic p1(input logic r, input logic w, input logic l, input logic [12:0] a, input logic [15:0] d);
        req1 = r; we1 = w; lock1 = l; add1 = a; wr1 = d;
    endtask

    task automatic reset_model();
        q.delete();
        exp_rd0 = 16'h0000;
        exp_rd1 = 16'h0000;
    endtask

    // One clock cycle: check outputs at negedge against expected grants and the scoreboard.
    task automatic cyc(input logic eg0, input logic eg1);
        rd_t         e;
        logic        ev0, ev1, ewe;
        logic [12:0] eadd;
        logic [15:0] ewr;
        @(negedge clk);
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (q.size() > 0 && q[0].due == cycn) begin
            e = q.pop_front();
            if (e.port) begin
                ev1 = 1'b1;
                exp_rd1 = e.data;
            end else begin
                ev0 = 1'b1;
                exp_rd0 = e.data;
            end
        end
        chk("vld0", {31'd0, vld0}, {31'd0, ev0});
        chk("vld1", {31'd0, vld1}, {31'd0, ev1});
        chk("rd0", {16'd0, rd0}, {16'd0, exp_rd0});
        chk("rd1", {16'd0, rd1}, {16'd0, exp_rd1});
        chk("gnt0", {31'd0, gnt0}, {31'd0, eg0});
        chk("gnt1", {31'd0, gnt1}, {31'd0, eg1});
        if (eg1) begin
            ewe = we1; eadd = add1; ewr = wr1;
        end else if (eg0) begin
            ewe = we0; eadd = add0; ewr = wr0;
        end else begin
            ewe = 1'b0; eadd = add0; ewr = wr0;
        end
        chk("mem_we", {31'd0, mem_we}, {31'd0, ewe});
        chk("mem_add", {19'd0, mem_add}, {19'd0, eadd});
        chk("mem_wr", {16'd0, mem_wr}, {16'd0, ewr});
        if (eg0 || eg1) begin
            if (ewe) begin
                model_mem[eadd] = ewr;
            end else begin
                q.push_back('{port: eg1, data: model_mem[eadd], due: cycn + 1});
            end
        end
        @(posedge clk);
        cycn++;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) model_mem[i] = init_val(13'(i));
        reset_model();

        // Reset with both requests high
        rst = 1'b1;
        p0(1'b1, 1'b0, 1'b0, 13'h0005, 16'h0000);
        p1(1'b1, 1'b0, 1'b0, 13'h0006, 16'h0000);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        rst = 1'b0;

        // Port 0 write then port 1 read of the same address
        p1(1'b0, 1'b0, 1'b0, 13'h0000, 16'h0000);
        p0(1'b1, 1'b1, 1'b0, 13'h0010, 16'hBEEF);
        cyc(1'b1, 1'b0);
        p0(1'b0, 1'b0, 1'b0, 13'h0000, 16'h0000);
        p1(1'b1, 1'b0, 1'b0, 13'h0010, 16'h0000);
        cyc(1'b0, 1'b1);
        p1(1'b0, 1'b0, 1'b0, 13'h0000, 16'h0000);
        cyc(1'b0, 1'b0);
        chk("rd1_beef", {16'd0, rd1}, {16'd0, 16'hBEEF});

        // Contention without lock for 4 cycles
        p0(1'b1, 1'b0, 1'b0, 13'h0020, 16'h0000);
        p1(1'b1, 1'b0, 1'b0, 13'h0030, 16'h0000);
`ifdef RAM_ARB_RR_EN
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
`else
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
`endif
        p0(1'b0, 1'b0, 1'b0, 13'h0000, 16'h0000);
        p1(1'b0, 1'b0, 1'b0, 13'h0000, 16'h0000);
        cyc(1'b0, 1'b0);

        // Locked burst on port 0 while port 1 waits
        p0(1'b1, 1'b0, 1'b1, 13'h0100, 16'h0000);
        cyc(1'b1, 1'b0);
        p1(1'b1, 1'b0, 1'b0, 13'h0040, 16'h0000);
        for (int i = 1; i < 4; i++) begin
            add0 = 13'h0100 + 13'(i);
            cyc(1'b1, 1'b0);
        end
        p0(1'b0, 1'b0, 1'b0, 13'h0000, 16'h0000);
        cyc(1'b0, 1'b1);
        p1(1'b0, 1'b0, 1'b0, 13'h0000, 16'h0000);
        cyc(1'b0, 1'b0);

        // Reset right after a granted read discards it
        p0(1'b1, 1'b0, 1'b0, 13'h0050, 16'h0000);
        cyc(1'b1, 1'b0);
        rst = 1'b1;
        reset_model();
        p0(1'b1, 1'b0, 1'b0, 13'h0060, 16'h0000);
        p1(1'b1, 1'b0, 1'b0, 13'h0070, 16'h0000);
        cyc(1'b0, 1'b0);
        rst = 1'b0;
`ifdef RAM_ARB_RR_EN
        cyc(1'b1, 1'b0);
`else
        cyc(1'b0, 1'b1);
`endif
        p0(1'b0, 1'b0, 1'b0, 13'h0000, 16'h0000);
        p1(1'b0, 1'b0, 1'b0, 13'h0000, 16'h0000);
        cyc(1'b0, 1'b0);

        // Top address: read old value, then write, then read back
        p1(1'b1, 1'b0, 1'b0, 13'h1FFF, 16'h0000);
        cyc(1'b0, 1'b1);
        p1(1'b0, 1'b0, 1'b0, 13'h0000, 16'h0000);
        p0(1'b1, 1'b1, 1'b0, 13'h1FFF, 16'h1234);
        cyc(1'b1, 1'b0);
        chk("rd1_old", {16'd0, rd1}, {16'd0, init_val(13'h1FFF)});
        p0(1'b1, 1'b0, 1'b0, 13'h1FFF, 16'h0000);
        cyc(1'b1, 1'b0);
        p0(1'b0, 1'b0, 1'b0, 13'h0000, 16'h0000);
        cyc(1'b0, 1'b0);
        chk("rd0_new", {16'd0, rd0}, {16'd0, 16'h1234});
        cyc(1'b0, 1'b0);

        chk("drain", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
